// File: rtl/bp_profiler_pkg.sv
// Shared types and address offsets for the core profiler blocks.
package bp_profiler_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StClear = 2'd1,
    StRun   = 2'd2,
    StDone  = 2'd3
  } bp_stall_profile_state_e;

  typedef enum logic [1:0] {
    CmdNop   = 2'd0,
    CmdStart = 2'd1,
    CmdStop  = 2'd2,
    CmdClear = 2'd3
  } bp_stall_profile_cmd_e;

  // Counters placed after the R reason counters.
  localparam int unsigned BpInstretOfs = 0;
  localparam int unsigned BpCyclesOfs  = 1;
  localparam int unsigned BpUnattrOfs  = 2;
  localparam int unsigned BpNumExtra   = 3;

endpackage

// File: rtl/bp_stall_profile_counter_bank.sv
// Stall-histogram counter array: saturating increment, clear-write and registered read port.
module bp_stall_profile_counter_bank
  import bp_profiler_pkg::*;
#(
  parameter int unsigned reason_width_p  = 6,
  parameter int unsigned counter_width_p = 32,
  localparam int unsigned num_cnt_lp     = (2 ** reason_width_p) + BpNumExtra,
  localparam int unsigned idx_width_lp   = $clog2(num_cnt_lp)
) (
  input  logic                       clk_i,
  input  logic                       reset_li,
  input  logic                       clr_v_i,
  input  logic [idx_width_lp-1:0]    clr_idx_i,
  input  logic                       inc_v_i,
  input  logic [idx_width_lp-1:0]    inc_idx_i,
  input  logic                       rd_v_i,
  input  logic [reason_width_p+1:0]  rd_addr_i,
  output logic                       rd_data_v_o,
  output logic [counter_width_p-1:0] rd_data_o,
  output logic                       sat_o
);

  localparam int unsigned cyc_idx_lp = (2 ** reason_width_p) + BpCyclesOfs;
  localparam logic [reason_width_p+1:0] num_cnt_addr_lp = num_cnt_lp[reason_width_p+1:0];

  logic [counter_width_p-1:0] mem_q [num_cnt_lp];
  logic [counter_width_p-1:0] mem_d [num_cnt_lp];
  logic [counter_width_p-1:0] rd_data_q, rd_data_d;
  logic                       rd_data_v_q, rd_data_v_d;

  function automatic logic [counter_width_p-1:0] sat_inc(input logic [counter_width_p-1:0] v);
    return (&v) ? v : v + counter_width_p'(1);
  endfunction

  // Each increment also bumps the elapsed-cycle counter.
  always_comb begin
    mem_d = mem_q;
    if (clr_v_i) begin
      mem_d[clr_idx_i] = '0;
    end else if (inc_v_i) begin
      mem_d[inc_idx_i]  = sat_inc(mem_q[inc_idx_i]);
      mem_d[cyc_idx_lp] = sat_inc(mem_q[cyc_idx_lp]);
    end
  end

  assign sat_o = inc_v_i & ~clr_v_i & ((&mem_q[inc_idx_i]) | (&mem_q[cyc_idx_lp]));

  always_comb begin
    rd_data_v_d = rd_v_i;
    rd_data_d   = rd_data_q;
    if (rd_v_i) begin
      rd_data_d = (rd_addr_i < num_cnt_addr_lp) ? mem_q[rd_addr_i[idx_width_lp-1:0]] : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      rd_data_q   <= '0;
      rd_data_v_q <= 1'b0;
    end else begin
      rd_data_q   <= rd_data_d;
      rd_data_v_q <= rd_data_v_d;
    end
  end

  assign rd_data_o   = rd_data_q;
  assign rd_data_v_o = rd_data_v_q;

endmodule

// File: rtl/bp_stall_profile_ctrl.sv
// Stall-reason histogram controller: clear/run/stop sequencing and shared counter-bank access.
// Optional interrupt output enabled by defining BP_STALL_PROFILE_IRQ_EN.
module bp_stall_profile_ctrl
  import bp_profiler_pkg::*;
#(
  parameter int unsigned reason_width_p  = 6,
  parameter int unsigned counter_width_p = 32,
  parameter int unsigned window_width_p  = 32
) (
  input  logic                       clk_i,
  input  logic                       reset_li,
`ifdef BP_STALL_PROFILE_IRQ_EN
  output logic                       irq_o,
  input  logic                       irq_ack_i,
`endif
  input  logic                       freeze_i,
  input  logic                       stall_v_i,
  input  logic [reason_width_p-1:0]  stall_reason_i,
  input  logic                       instret_i,
  input  logic                       cmd_v_i,
  input  logic [1:0]                 cmd_i,
  output logic                       cmd_ready_o,
  input  logic [window_width_p-1:0]  window_i,
  output logic [1:0]                 state_o,
  output logic                       overflow_o,
  input  logic                       rd_v_i,
  input  logic [reason_width_p+1:0]  rd_addr_i,
  output logic                       rd_data_v_o,
  output logic [counter_width_p-1:0] rd_data_o
);

  localparam int unsigned num_reason_lp = 2 ** reason_width_p;
  localparam int unsigned num_cnt_lp    = num_reason_lp + BpNumExtra;
  localparam int unsigned idx_width_lp  = $clog2(num_cnt_lp);
  localparam logic [idx_width_lp-1:0] instret_idx_lp = idx_width_lp'(num_reason_lp + BpInstretOfs);
  localparam logic [idx_width_lp-1:0] unattr_idx_lp  = idx_width_lp'(num_reason_lp + BpUnattrOfs);
  localparam logic [idx_width_lp-1:0] last_idx_lp    = idx_width_lp'(num_cnt_lp - 1);

  bp_stall_profile_state_e   state_q, state_d;
  bp_stall_profile_cmd_e     cmd;
  logic [window_width_p-1:0] window_q, window_d;
  logic [window_width_p-1:0] elapsed_q, elapsed_d;
  logic [idx_width_lp-1:0]   clr_idx_q, clr_idx_d;
  logic [idx_width_lp-1:0]   inc_idx;
  logic                      cmd_ready_q, cmd_ready_d;
  logic                      overflow_q, overflow_d;
  logic                      cmd_acc, count, clr_v, expire, sat;

  assign cmd     = bp_stall_profile_cmd_e'(cmd_i);
  assign cmd_acc = cmd_v_i & cmd_ready_q;

  always_comb begin
    state_d   = state_q;
    window_d  = window_q;
    elapsed_d = elapsed_q;
    clr_idx_d = clr_idx_q;
    count     = 1'b0;
    clr_v     = 1'b0;
    expire    = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (cmd_acc && cmd == CmdStart) begin
          state_d   = StRun;
          window_d  = window_i;
          elapsed_d = '0;
        end else if (cmd_acc && cmd == CmdClear) begin
          state_d   = StClear;
          clr_idx_d = '0;
        end
      end
      StClear: begin
        clr_v = 1'b1;
        if (clr_idx_q == last_idx_lp) begin
          state_d = StIdle;
        end else begin
          clr_idx_d = clr_idx_q + idx_width_lp'(1);
        end
      end
      StRun: begin
        // Expiry is seen the cycle after the last counted one, so that cycle is never counted.
        expire = (window_q != '0) && (elapsed_q == window_q);
        if (expire || (cmd_acc && cmd == CmdStop)) begin
          state_d = StDone;
        end else if (!freeze_i) begin
          count = 1'b1;
          if (!(&elapsed_q)) begin
            elapsed_d = elapsed_q + window_width_p'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
    cmd_ready_d = (state_d != StClear);
    overflow_d  = (state_d == StClear) ? 1'b0 : (overflow_q | sat);
  end

  always_comb begin
    if (instret_i) begin
      inc_idx = instret_idx_lp;
    end else if (stall_v_i) begin
      inc_idx = idx_width_lp'(stall_reason_i);
    end else begin
      inc_idx = unattr_idx_lp;
    end
  end

  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      state_q     <= StIdle;
      window_q    <= '0;
      elapsed_q   <= '0;
      clr_idx_q   <= '0;
      cmd_ready_q <= 1'b1;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      window_q    <= window_d;
      elapsed_q   <= elapsed_d;
      clr_idx_q   <= clr_idx_d;
      cmd_ready_q <= cmd_ready_d;
      overflow_q  <= overflow_d;
    end
  end

  assign state_o     = state_q;
  assign cmd_ready_o = cmd_ready_q;
  assign overflow_o  = overflow_q;

  bp_stall_profile_counter_bank #(
    .reason_width_p (reason_width_p),
    .counter_width_p(counter_width_p)
  ) u_bank (
    .clk_i      (clk_i),
    .reset_li   (reset_li),
    .clr_v_i    (clr_v),
    .clr_idx_i  (clr_idx_q),
    .inc_v_i    (count),
    .inc_idx_i  (inc_idx),
    .rd_v_i     (rd_v_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_v_o(rd_data_v_o),
    .rd_data_o  (rd_data_o),
    .sat_o      (sat)
  );

`ifdef BP_STALL_PROFILE_IRQ_EN
  logic irq_q, irq_d;

  // A new event wins over an acknowledge in the same cycle.
  assign irq_d = expire | (overflow_d & ~overflow_q) | (irq_q & ~irq_ack_i);

  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_bp_stall_profile_ctrl.sv
// Self-checking bench: two instances (32-bit and 4-bit counters) share stimulus and a reference model.
module tb_bp_stall_profile_ctrl;

  localparam int     NC    = 67;
  localparam longint Max32 = 64'h0000_0000_FFFF_FFFF;
  localparam longint Max4  = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_li, freeze, stall_v, instret, cmd_v, rd_v;
  logic [5:0]  reason;
  logic [1:0]  cmd;
  logic [31:0] window;
  logic [7:0]  rd_addr;
  logic        ready_w, ready_n, ovf_w, ovf_n, rdv_w, rdv_n;
  logic [1:0]  st_w, st_n;
  logic [31:0] rd_w;
  logic [3:0]  rd_n;
`ifdef BP_STALL_PROFILE_IRQ_EN
  logic        irq_ack, irq_w, irq_n;
  bit          m_irq_w, m_irq_n;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: unbounded true counts, saturation applied when observed.
  longint     m_cnt [NC];
  bit         m_known [NC];
  logic [1:0] m_state;
  longint     m_elapsed, m_window;
  int         m_clr;
  bit         m_ovf_w, m_ovf_n;
  bit         exp_rd_v, exp_known;
  longint     exp_rd_w, exp_rd_n;

  bp_stall_profile_ctrl #(.reason_width_p(6), .counter_width_p(32), .window_width_p(32)) dut_w (
    .clk_i(clk), .reset_li(reset_li),
`ifdef BP_STALL_PROFILE_IRQ_EN
    .irq_o(irq_w), .irq_ack_i(irq_ack),
`endif
    .freeze_i(freeze), .stall_v_i(stall_v), .stall_reason_i(reason), .instret_i(instret),
    .cmd_v_i(cmd_v), .cmd_i(cmd), .cmd_ready_o(ready_w), .window_i(window), .state_o(st_w),
    .overflow_o(ovf_w), .rd_v_i(rd_v), .rd_addr_i(rd_addr), .rd_data_v_o(rdv_w), .rd_data_o(rd_w)
  );

  bp_stall_profile_ctrl #(.reason_width_p(6), .counter_width_p(4), .window_width_p(32)) dut_n (
    .clk_i(clk), .reset_li(reset_li),
`ifdef BP_STALL_PROFILE_IRQ_EN
    .irq_o(irq_n), .irq_ack_i(irq_ack),
`endif
    .freeze_i(freeze), .stall_v_i(stall_v), .stall_reason_i(reason), .instret_i(instret),
    .cmd_v_i(cmd_v), .cmd_i(cmd), .cmd_ready_o(ready_n), .window_i(window), .state_o(st_n),
    .overflow_o(ovf_n), .rd_v_i(rd_v), .rd_addr_i(rd_addr), .rd_data_v_o(rdv_n), .rd_data_o(rd_n)
  );

  function automatic longint sat(longint v, longint mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic void bump(int a);
    m_cnt[a]++;
    if (m_cnt[a] > Max4) m_ovf_n = 1'b1;
    if (m_cnt[a] > Max32) m_ovf_w = 1'b1;
  endfunction

  task automatic model_reset();
    m_state = 2'd0;
    m_ovf_w = 1'b0;
    m_ovf_n = 1'b0;
    for (int i = 0; i < NC; i++) m_known[i] = 1'b0;
`ifdef BP_STALL_PROFILE_IRQ_EN
    m_irq_w = 1'b0;
    m_irq_n = 1'b0;
`endif
  endtask

  task automatic idle_inputs();
    freeze = 0; stall_v = 0; instret = 0; cmd_v = 0; cmd = 0; rd_v = 0; reason = 0;
    rd_addr = 0; window = 0;
`ifdef BP_STALL_PROFILE_IRQ_EN
    irq_ack = 0;
`endif
  endtask

  // Advance one clock: apply the spec rules to the current inputs, then cross the edge.
  task automatic step();
    bit acc, expire, stop, pw, pn;
    int tgt;
    acc = cmd_v && (m_state != 2'd1);
    exp_rd_v = rd_v;
    if (rd_v) begin
      if (int'(rd_addr) < NC) begin
        exp_known = m_known[rd_addr];
        exp_rd_w  = sat(m_cnt[rd_addr], Max32);
        exp_rd_n  = sat(m_cnt[rd_addr], Max4);
      end else begin
        exp_known = 1'b1; exp_rd_w = 0; exp_rd_n = 0;
      end
    end
    pw = m_ovf_w; pn = m_ovf_n; expire = 1'b0;
    case (m_state)
      2'd0, 2'd3: begin
        if (acc && cmd == 2'd1) begin
          m_state = 2'd2; m_window = window; m_elapsed = 0;
        end else if (acc && cmd == 2'd3) begin
          m_state = 2'd1; m_clr = 0; m_ovf_w = 0; m_ovf_n = 0;
        end
      end
      2'd1: begin
        m_cnt[m_clr] = 0; m_known[m_clr] = 1'b1; m_clr++;
        if (m_clr == NC) m_state = 2'd0;
      end
      default: begin
        expire = (m_window != 0) && (m_elapsed == m_window);
        stop   = acc && cmd == 2'd2;
        if (expire || stop) m_state = 2'd3;
        else if (!freeze) begin
          m_elapsed++;
          bump(65);
          tgt = instret ? 64 : (stall_v ? int'(reason) : 66);
          bump(tgt);
        end
      end
    endcase
`ifdef BP_STALL_PROFILE_IRQ_EN
    m_irq_w = expire || (m_ovf_w && !pw) || (m_irq_w && !irq_ack);
    m_irq_n = expire || (m_ovf_n && !pn) || (m_irq_n && !irq_ack);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic cmd_issue(input logic [1:0] c, input logic [31:0] w);
    cmd_v = 1; cmd = c; window = w;
    step();
    cmd_v = 0; cmd = 0;
  endtask

  task automatic read_addr(input logic [7:0] a);
    rd_v = 1; rd_addr = a;
    step();
    rd_v = 0;
  endtask

  task automatic to_idle_or_done();
    if (m_state == 2'd2) cmd_issue(2'd2, 0);
    for (int i = 0; i < 100 && m_state == 2'd1; i++) step();
  endtask

  task automatic clear_all();
    idle_inputs();
    to_idle_or_done();
    cmd_issue(2'd3, 0);
    for (int i = 0; i < 100 && m_state == 2'd1; i++) step();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_li = 0;
    repeat (3) @(posedge clk);
    #1 reset_li = 1;
    model_reset();
    checks += 6;
    if (st_w !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", st_w); end
    if (ready_w !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0b expected 1", ready_w); end
    if (ovf_w !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %0b expected 0", ovf_w); end
    if (rdv_w !== 1'b0) begin failures++; $display("FAIL reset_rdv: got %0b expected 0", rdv_w); end
    if (rd_w !== 32'd0) begin failures++; $display("FAIL reset_rdata: got %0d expected 0", rd_w); end
    if (st_n !== 2'd0) begin failures++; $display("FAIL reset_state_n: got %0d expected 0", st_n); end
  endtask

  task automatic test_clear();
    int busy = 0;
    cmd_issue(2'd3, 0);
    for (int i = 0; i < 100 && ready_w === 1'b0; i++) begin busy++; step(); end
    checks += 2;
    if (busy != 67) begin failures++; $display("FAIL clear_busy_cycles: got %0d expected 67", busy); end
    if (st_w !== 2'd0) begin failures++; $display("FAIL clear_end_state: got %0d expected 0", st_w); end
    for (int a = 0; a < 70; a++) begin
      read_addr(8'(a));
      checks += 2;
      if (rdv_w !== 1'b1 || rd_w !== 32'd0) begin
        failures++; $display("FAIL clear_read_%0d: got v=%0b d=%0d expected v=1 d=0", a, rdv_w, rd_w);
      end
      if (rd_n !== 4'd0) begin failures++; $display("FAIL clear_read_n_%0d: got %0d expected 0", a, rd_n); end
    end
    read_addr(8'd255);
    checks++;
    if (rd_w !== 32'd0) begin failures++; $display("FAIL read_out_of_map: got %0d expected 0", rd_w); end
  endtask

  task automatic test_window();
    int addrs [5] = '{5, 64, 65, 66, 9};
    int exps [5]  = '{4, 3, 10, 3, 0};
    cmd_issue(2'd1, 32'd10);
    stall_v = 1; reason = 5;
    repeat (4) step();
    instret = 1; reason = 9;  // instret outranks a simultaneous stall
    repeat (3) step();
    instret = 0; stall_v = 0;
    repeat (3) step();
    checks++;
    if (st_w !== 2'd2) begin failures++; $display("FAIL window_still_run: got %0d expected 2", st_w); end
    step();
    checks++;
    if (st_w !== 2'd3) begin failures++; $display("FAIL window_done: got %0d expected 3", st_w); end
    for (int i = 0; i < 5; i++) begin
      read_addr(8'(addrs[i]));
      checks++;
      if (rd_w !== 32'(exps[i])) begin
        failures++; $display("FAIL window_addr%0d: got %0d expected %0d", addrs[i], rd_w, exps[i]);
      end
    end
  endtask

  task automatic test_freeze_stop();
    bit frz [20];
    int n = 0;
    clear_all();
    while (n < 7) begin
      int p = $urandom_range(19);
      if (!frz[p]) begin frz[p] = 1; n++; end
    end
    cmd_issue(2'd1, 0);
    for (int i = 0; i < 20; i++) begin
      freeze = frz[i]; stall_v = 1'($urandom); instret = 1'($urandom); reason = 6'($urandom);
      step();
    end
    idle_inputs();
    cmd_issue(2'd2, 0);
    checks++;
    if (st_w !== 2'd3) begin failures++; $display("FAIL freeze_stop_state: got %0d expected 3", st_w); end
    read_addr(8'd65);
    checks++;
    if (rd_w !== 32'd13) begin failures++; $display("FAIL freeze_elapsed: got %0d expected 13", rd_w); end
    read_addr(8'd64);
    checks++;
    if (rd_w !== exp_rd_w[31:0]) begin
      failures++; $display("FAIL freeze_instret: got %0d expected %0d", rd_w, exp_rd_w);
    end
    clear_all();
    cmd_issue(2'd1, 32'd3);
    repeat (3) step();
    cmd_issue(2'd2, 0);
    checks++;
    if (st_w !== 2'd3) begin failures++; $display("FAIL stop_expire_state: got %0d expected 3", st_w); end
    read_addr(8'd65);
    checks++;
    if (rd_w !== 32'd3) begin failures++; $display("FAIL stop_expire_elapsed: got %0d expected 3", rd_w); end
  endtask

  task automatic test_read_same_cycle();
    clear_all();
    cmd_issue(2'd1, 0);
    stall_v = 1; reason = 5;
    repeat (3) step();
    read_addr(8'd5);
    checks++;
    if (rd_w !== 32'd3) begin failures++; $display("FAIL read_during_inc: got %0d expected 3", rd_w); end
    idle_inputs();
    cmd_issue(2'd2, 0);
    read_addr(8'd5);
    checks++;
    if (rd_w !== 32'd4) begin failures++; $display("FAIL read_after_inc: got %0d expected 4", rd_w); end
  endtask

  task automatic test_saturate();
    clear_all();
    cmd_issue(2'd1, 0);
    stall_v = 1; reason = 2;
    repeat (20) step();
    idle_inputs();
    cmd_issue(2'd2, 0);
    read_addr(8'd2);
    checks += 4;
    if (rd_n !== 4'd15) begin failures++; $display("FAIL sat_value_n: got %0d expected 15", rd_n); end
    if (rd_w !== 32'd20) begin failures++; $display("FAIL sat_value_w: got %0d expected 20", rd_w); end
    if (ovf_n !== 1'b1) begin failures++; $display("FAIL sat_overflow_n: got %0b expected 1", ovf_n); end
    if (ovf_w !== 1'b0) begin failures++; $display("FAIL sat_overflow_w: got %0b expected 0", ovf_w); end
    cmd_issue(2'd3, 0);
    checks++;
    if (ovf_n !== 1'b0) begin failures++; $display("FAIL clear_overflow: got %0b expected 0", ovf_n); end
    for (int i = 0; i < 100 && m_state == 2'd1; i++) step();
  endtask

  task automatic test_random();
    clear_all();
    for (int i = 0; i < 400; i++) begin
      cmd_v   = ($urandom_range(7) == 0);
      cmd     = 2'($urandom);
      window  = 32'($urandom_range(30));
      freeze  = ($urandom_range(3) == 0);
      stall_v = 1'($urandom);
      reason  = 6'($urandom_range(7));
      instret = ($urandom_range(2) == 0);
      rd_v    = 1'($urandom);
      rd_addr = ($urandom_range(9) == 0) ? 8'($urandom) : 8'($urandom_range(69));
`ifdef BP_STALL_PROFILE_IRQ_EN
      irq_ack = ($urandom_range(3) == 0);
`endif
      step();
      checks += 4;
      if (st_w !== m_state) begin failures++; $display("FAIL rnd_state: got %0d expected %0d", st_w, m_state); end
      if (ready_w !== (m_state != 2'd1)) begin
        failures++; $display("FAIL rnd_ready: got %0b expected %0b", ready_w, m_state != 2'd1);
      end
      if (ovf_n !== m_ovf_n) begin failures++; $display("FAIL rnd_ovf_n: got %0b expected %0b", ovf_n, m_ovf_n); end
      if (rdv_w !== exp_rd_v) begin failures++; $display("FAIL rnd_rdv: got %0b expected %0b", rdv_w, exp_rd_v); end
      if (exp_rd_v && exp_known) begin
        checks += 2;
        if (rd_w !== exp_rd_w[31:0]) begin
          failures++; $display("FAIL rnd_rd_w: got %0d expected %0d", rd_w, exp_rd_w);
        end
        if (rd_n !== exp_rd_n[3:0]) begin
          failures++; $display("FAIL rnd_rd_n: got %0d expected %0d", rd_n, exp_rd_n);
        end
      end
`ifdef BP_STALL_PROFILE_IRQ_EN
      checks += 2;
      if (irq_w !== m_irq_w) begin failures++; $display("FAIL rnd_irq_w: got %0b expected %0b", irq_w, m_irq_w); end
      if (irq_n !== m_irq_n) begin failures++; $display("FAIL rnd_irq_n: got %0b expected %0b", irq_n, m_irq_n); end
`endif
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_clear();
    idle_inputs();
    to_idle_or_done();
    cmd_issue(2'd3, 0);
    repeat (10) step();
    #2 reset_li = 0;
    #1;
    checks += 3;
    if (st_w !== 2'd0) begin failures++; $display("FAIL midclear_reset_state: got %0d expected 0", st_w); end
    if (ready_w !== 1'b1) begin failures++; $display("FAIL midclear_reset_ready: got %0b expected 1", ready_w); end
    if (st_n !== 2'd0) begin failures++; $display("FAIL midclear_reset_state_n: got %0d expected 0", st_n); end
    #3 reset_li = 1;
    model_reset();
    clear_all();
    read_addr(8'd40);
    checks++;
    if (rd_w !== 32'd0) begin failures++; $display("FAIL after_reset_clear: got %0d expected 0", rd_w); end
  endtask

`ifdef BP_STALL_PROFILE_IRQ_EN
  task automatic test_irq();
    clear_all();
    irq_ack = 1;
    step();
    irq_ack = 0;
    cmd_issue(2'd1, 32'd5);
    repeat (5) step();
    checks++;
    if (irq_w !== 1'b0) begin failures++; $display("FAIL irq_before_expire: got %0b expected 0", irq_w); end
    step();
    repeat (3) step();
    checks++;
    if (irq_w !== 1'b1) begin failures++; $display("FAIL irq_held: got %0b expected 1", irq_w); end
    irq_ack = 1;
    step();
    irq_ack = 0;
    checks++;
    if (irq_w !== 1'b0) begin failures++; $display("FAIL irq_ack: got %0b expected 0", irq_w); end
    clear_all();
    cmd_issue(2'd1, 0);
    irq_ack = 1; stall_v = 1; reason = 2;
    repeat (15) step();
    checks++;
    if (ovf_n !== 1'b0) begin failures++; $display("FAIL irq_pre_ovf: got %0b expected 0", ovf_n); end
    step();
    checks += 2;
    if (irq_n !== 1'b1) begin failures++; $display("FAIL irq_ovf_with_ack: got %0b expected 1", irq_n); end
    if (irq_w !== 1'b0) begin failures++; $display("FAIL irq_no_ovf_w: got %0b expected 0", irq_w); end
    step();
    checks++;
    if (irq_n !== 1'b0) begin failures++; $display("FAIL irq_ovf_acked: got %0b expected 0", irq_n); end
    idle_inputs();
  endtask
`endif

  initial begin
    idle_inputs();
    reset_li = 0;
    m_state = 0;
    for (int i = 0; i < NC; i++) m_cnt[i] = 0;
    test_reset();
    test_clear();
    test_window();
    test_freeze_stop();
    test_read_same_cycle();
    test_saturate();
    test_random();
    test_reset_mid_clear();
`ifdef BP_STALL_PROFILE_IRQ_EN
    test_irq();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
